// File: rtl/mem_pkg.sv
// Shared types and limits for the req/gnt/rvalid memory responder.
package mem_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int MAX_RD_LATENCY = 8;
  localparam int MAX_GNT_DELAY  = 15;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  typedef enum logic {
    GNT_IDLE,
    GNT_WAIT
  } gnt_state_e;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response delay line; stage 0 is loaded on the accept edge.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_rsp_t rsp_in,
  output mem_rsp_t rsp_out
);

  mem_rsp_t stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= rsp_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign rsp_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port word RAM answering the core's req/gnt/rvalid interface with
// a programmable grant delay and a fixed response latency.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_LATENCY = 1,
  parameter int          GNT_DELAY  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * WORD_BYTES);
  localparam int          CNT_W     = $clog2(MAX_GNT_DELAY + 1);

  mem_req_t       req;
  logic [31:0]    offset;
  logic           in_range;
  logic [AW-1:0]  word_idx;
  logic           accept;
  mem_rsp_t       rsp_in;
  mem_rsp_t       rsp_out;
  logic [31:0]    mem [MEM_WORDS];

  assign req      = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
  assign offset   = req.addr - BASE_ADDR;
  assign in_range = offset < MEM_BYTES;
  assign word_idx = offset[AW+1:2];
  assign accept   = req_i && gnt_o;

  generate
    if (GNT_DELAY == 0) begin : g_gnt_comb
      assign gnt_o = req_i;
    end else begin : g_gnt_fsm
      localparam logic [CNT_W-1:0] DELAY = CNT_W'(GNT_DELAY);

      gnt_state_e       state_q;
      logic [CNT_W-1:0] cnt_q;
      logic             gnt_q;

      // gnt_q always equals (state_q == GNT_WAIT && cnt_q == DELAY), kept in a flop.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q <= GNT_IDLE;
          cnt_q   <= '0;
          gnt_q   <= 1'b0;
        end else begin
          case (state_q)
            GNT_IDLE: begin
              if (req_i) begin
                state_q <= GNT_WAIT;
                cnt_q   <= CNT_W'(1);
                gnt_q   <= (DELAY == CNT_W'(1));
              end
            end
            GNT_WAIT: begin
              if (!req_i || gnt_q) begin
                state_q <= GNT_IDLE;
                gnt_q   <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                gnt_q <= ((cnt_q + CNT_W'(1)) == DELAY);
              end
            end
            default: state_q <= GNT_IDLE;
          endcase
        end
      end

      assign gnt_o = gnt_q;
    end
  endgenerate

  // NOTE: RAM has no reset branch so it maps onto block RAM; contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && req.we && in_range) begin
      for (int n = 0; n < WORD_BYTES; n++) begin
        if (req.be[n]) mem[word_idx][8*n +: 8] <= req.wdata[8*n +: 8];
      end
    end
  end

  // Read data is zeroed here so the pipeline output is 0 whenever rvalid is low.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.err   = accept && !in_range;
    if (accept && !req.we && in_range) rsp_in.rdata = mem[word_idx];
  end

  mem_resp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign rvalid_o = rsp_out.valid;
  assign err_o    = rsp_out.err;
  assign rdata_o  = rsp_out.rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: four responder instances with different grant/latency settings.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst3;
  logic        req   [4];
  logic        we    [4];
  logic [3:0]  be    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic        gnt   [4];
  logic        rvalid[4];
  logic        err   [4];
  logic [31:0] rdata [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  mem_responder #(.GNT_DELAY(3), .RD_LATENCY(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  mem_responder #(.RD_LATENCY(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  mem_responder #(.RD_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst3), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]),
    .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]),
    .rdata_o(rdata[3]), .err_o(err[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req[k]   = r;
    we[k]    = w;
    addr[k]  = a;
    be[k]    = b;
    wdata[k] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waits;
    rst_n = 1'b0;
    rst3  = 1'b0;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset state
    mid();
    for (int k = 0; k < 4; k++) begin
      check_bit($sformatf("rst rvalid u%0d", k), rvalid[k], 1'b0);
      check($sformatf("rst rdata u%0d", k), rdata[k], 32'h0);
      check_bit($sformatf("rst err u%0d", k), err[k], 1'b0);
    end
    check_bit("rst gnt u1", gnt[1], 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    rst3  = 1'b1;
    next_cycle();

    // u0: basic write/read, byte enables, out of range
    drive(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hA5A5_0000);
    mid(); check_bit("u0 wr0 gnt", gnt[0], 1'b1); next_cycle();
    drive(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    mid(); check_bit("u0 wr10 gnt", gnt[0], 1'b1);
    check_bit("u0 wr0 rvalid", rvalid[0], 1'b1); next_cycle();
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    mid(); check_bit("u0 rd10 gnt", gnt[0], 1'b1);
    check_bit("u0 wr10 rvalid", rvalid[0], 1'b1);
    check("u0 wr10 rdata", rdata[0], 32'h0);
    check_bit("u0 wr10 err", err[0], 1'b0); next_cycle();
    drive(0, 1'b1, 1'b1, 32'h10, 4'b0101, 32'h1122_3344);
    mid(); check_bit("u0 rd10 rvalid", rvalid[0], 1'b1);
    check("u0 rd10 rdata", rdata[0], 32'hDEAD_BEEF);
    check_bit("u0 rd10 err", err[0], 1'b0); next_cycle();
    drive(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    mid(); check_bit("u0 wrbe rvalid", rvalid[0], 1'b1);
    check("u0 wrbe rdata", rdata[0], 32'h0); next_cycle();
    drive(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
    mid(); check("u0 rdbe rdata", rdata[0], 32'hDE22_BE44); next_cycle();
    drive(0, 1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF);
    mid(); check_bit("u0 oor rd rvalid", rvalid[0], 1'b1);
    check_bit("u0 oor rd err", err[0], 1'b1);
    check("u0 oor rd rdata", rdata[0], 32'h0); next_cycle();
    drive(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    mid(); check_bit("u0 oor wr rvalid", rvalid[0], 1'b1);
    check_bit("u0 oor wr err", err[0], 1'b1); next_cycle();
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid(); check_bit("u0 rd0 rvalid", rvalid[0], 1'b1);
    check_bit("u0 rd0 err", err[0], 1'b0);
    check("u0 rd0 rdata", rdata[0], 32'hA5A5_0000); next_cycle();
    mid(); check_bit("u0 idle rvalid", rvalid[0], 1'b0);
    check("u0 idle rdata", rdata[0], 32'h0); next_cycle();

    // u1: grant delay 3, latency 2
    drive(1, 1'b1, 1'b1, 32'h0, 4'hF, 32'h1357_9BDF);
    waits = 0;
    mid();
    while (!gnt[1] && waits < 20) begin
      next_cycle(); mid(); waits++;
    end
    check_bit("u1 wr gnt", gnt[1], 1'b1);
    check("u1 wr wait", 32'(waits), 32'd3);
    next_cycle();
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) next_cycle();
    drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      mid();
      check_bit($sformatf("u1 gnt c%0d", c), gnt[1], (c % 4) == 3);
      check_bit($sformatf("u1 rvalid c%0d", c), rvalid[1], (c >= 5) && ((c % 4) == 1));
      if (c == 5 || c == 9) check($sformatf("u1 rdata c%0d", c), rdata[1], 32'h1357_9BDF);
      next_cycle();
    end
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid(); check_bit("u1 rvalid c12", rvalid[1], 1'b0); next_cycle();
    mid(); check_bit("u1 rvalid c13", rvalid[1], 1'b1);
    check("u1 rdata c13", rdata[1], 32'h1357_9BDF); next_cycle();

    // u2: latency 4 streaming
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b1, 1'b1, 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i));
      next_cycle();
    end
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b1, 1'b0, 32'(4 * i), 4'h0, 32'h0);
      mid(); check_bit($sformatf("u2 early rvalid c%0d", i), rvalid[2], 1'b0);
      next_cycle();
    end
    drive(2, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      mid(); check_bit($sformatf("u2 rvalid c%0d", i + 4), rvalid[2], 1'b1);
      check($sformatf("u2 rdata c%0d", i + 4), rdata[2], 32'hC0DE_0000 + 32'(i));
      next_cycle();
    end
    mid(); check_bit("u2 rvalid c8", rvalid[2], 1'b0); next_cycle();

    // u3: reset while two reads are in flight
    drive(3, 1'b1, 1'b1, 32'h8, 4'hF, 32'h5A5A_1234);
    next_cycle();
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) next_cycle();
    drive(3, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    next_cycle();
    next_cycle();
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst3 = 1'b0;
    mid(); check_bit("u3 rst rvalid", rvalid[3], 1'b0);
    check("u3 rst rdata", rdata[3], 32'h0); next_cycle();
    rst3 = 1'b1;
    for (int c = 3; c < 7; c++) begin
      mid(); check_bit($sformatf("u3 late rvalid c%0d", c), rvalid[3], 1'b0);
      next_cycle();
    end
    drive(3, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    next_cycle();
    drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    mid(); check_bit("u3 post rvalid +1", rvalid[3], 1'b0); next_cycle();
    mid(); check_bit("u3 post rvalid +2", rvalid[3], 1'b0); next_cycle();
    mid(); check_bit("u3 post rvalid +3", rvalid[3], 1'b1);
    check("u3 post rdata", rdata[3], 32'h5A5A_1234); next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
